// File: rtl/cpu_decode_pkg.sv
// cpu_decode_pkg: form encodings, opcode class sets and the decoded-bundle type shared by the decode stage
package cpu_decode_pkg;
    localparam int OP_W = 8;
    // Defined form1 opcodes: 0x01-0x15 and 0x19-0x39; 0x00 (bad) and everything else is undefined
    localparam logic [63:0] DEF_MASK = 64'h03FF_FFFF_FE3F_FFFE;
    typedef enum logic [1:0] {FORM1 = 2'd0, FORM2 = 2'd2, FORM3 = 2'd3} form_e;
    typedef struct packed {
        logic            valid;
        form_e           form;
        logic [OP_W-1:0] op;
        logic [3:0]      ria;
        logic [3:0]      rib;
        logic            reg_we;
        logic [31:0]     imm;
        logic            mem_rd;
        logic            mem_wr;
        logic            illegal;
        logic [31:0]     pc;
    } bundle_t;
    function automatic logic is_operand(input logic [7:0] op);
        return op inside {8'h01, 8'h03, 8'h08, 8'h09, 8'h0c, 8'h0d, 8'h1a, 8'h1b, 8'h1d, 8'h1e,
                          8'h20, 8'h22, 8'h23, [8'h36:8'h39]};
    endfunction
    function automatic logic is_load(input logic [7:0] op);
        return op inside {8'h06, 8'h08, 8'h0c, 8'h1c, 8'h1d, 8'h21, 8'h22, 8'h36, 8'h38};
    endfunction
    function automatic logic is_store(input logic [7:0] op);
        return op inside {8'h09, 8'h0b, 8'h0d, 8'h1e, 8'h1f, 8'h23, 8'h24, 8'h37, 8'h39};
    endfunction
    // ALU, move and load-immediate ops that write riA
    function automatic logic is_writer(input logic [7:0] op);
        return op inside {8'h01, 8'h02, 8'h05, [8'h10:8'h15], 8'h1b, 8'h20, [8'h26:8'h2f], [8'h31:8'h34]};
    endfunction
    // Register-register ops that read both riA and riB
    function automatic logic is_regreg(input logic [7:0] op);
        return op inside {8'h02, 8'h05, 8'h0e, [8'h10:8'h15], [8'h26:8'h2f], [8'h31:8'h34]};
    endfunction
    function automatic logic is_defined(input logic [7:0] op);
        return op[7:6] == 2'b00 && DEF_MASK[op[5:0]];
    endfunction
endpackage

// File: rtl/cpu_decode_comb.sv
// cpu_decode_comb: purely combinational moxie field and class decoder
//   opcode/operand/pc : instruction word, trailing immediate word and its address
//   dec               : decoded bundle (valid always 1; the parent qualifies it)
//   reads_a/reads_b   : instruction sources riA / riB (for the load-use interlock)
module cpu_decode_comb import cpu_decode_pkg::*; (
    input  logic [15:0] opcode,
    input  logic [31:0] operand,
    input  logic [31:0] pc,
    output bundle_t     dec,
    output logic        reads_a,
    output logic        reads_b
);
    logic [7:0] op1;
    logic       f1;
    logic       f2;
    assign op1 = opcode[15:8];
    assign f1  = ~opcode[15];
    assign f2  = opcode[15:14] == 2'b10;
    always_comb begin
        dec.valid   = 1'b1;
        dec.form    = f1 ? FORM1 : f2 ? FORM2 : FORM3;
        dec.op      = f1 ? op1 : f2 ? {6'b0, opcode[13:12]} : {4'b0, opcode[13:10]};
        dec.ria     = f2 ? opcode[11:8] : opcode[7:4];
        dec.rib     = opcode[3:0];
        // form3 offset is in halfwords; execute adds the byte offset to PC+2
        dec.imm     = f1 ? (is_operand(op1) ? operand : 32'd0) :
                      f2 ? {24'b0, opcode[7:0]} : {{21{opcode[9]}}, opcode[9:0], 1'b0};
        dec.mem_rd  = f1 & is_load(op1);
        dec.mem_wr  = f1 & is_store(op1);
        dec.illegal = f1 & ~is_defined(op1);
        dec.reg_we  = f1 ? (is_load(op1) | is_writer(op1)) : (f2 & (opcode[13:12] != 2'b11));
        dec.pc      = pc;
        reads_a     = f1 ? is_regreg(op1) : f2;
        reads_b     = f1 & (is_regreg(op1) | is_store(op1));
    end
endmodule

// File: rtl/cpu_decode.sv
// cpu_decode: moxie decode stage with registered bundle, stall/flush handling and load-use bubble
//   clk_i, rst_i (async, active-low)
//   opcode_i/operand_i/valid_i/PC_i : instruction from fetch
//   stall_i : execute holding, flush_i : kill held and incoming instruction
//   stall_o : decode not accepting (to fetch)
//   valid_o/form_o/op_o/riA_o/riB_o/reg_we_o/imm_o/mem_rd_o/mem_wr_o/illegal_o/PC_o : decoded bundle
module cpu_decode import cpu_decode_pkg::*; #(
    parameter int NUM_REGS = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [15:0]                 opcode_i,
    input  logic [31:0]                 operand_i,
    input  logic                        valid_i,
    input  logic [31:0]                 PC_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    output logic                        stall_o,
    output logic                        valid_o,
    output logic [1:0]                  form_o,
    output logic [OP_W-1:0]             op_o,
    output logic [$clog2(NUM_REGS)-1:0] riA_o,
    output logic [$clog2(NUM_REGS)-1:0] riB_o,
    output logic                        reg_we_o,
    output logic [31:0]                 imm_o,
    output logic                        mem_rd_o,
    output logic                        mem_wr_o,
    output logic                        illegal_o,
    output logic [31:0]                 PC_o
);
    localparam int RW = $clog2(NUM_REGS);
    bundle_t dec;
    bundle_t q;
    logic    reads_a;
    logic    reads_b;
    logic    hazard;
    logic    hz_q;
    cpu_decode_comb u_comb (
        .opcode  (opcode_i),
        .operand (operand_i),
        .pc      (PC_i),
        .dec     (dec),
        .reads_a (reads_a),
        .reads_b (reads_b)
    );
    // Incoming op reads the register the load now in the output bundle is about to write
    assign hazard  = valid_i & q.valid & q.mem_rd & ~hz_q &
                     ((reads_a & (dec.ria == q.ria)) | (reads_b & (dec.rib == q.ria)));
    assign stall_o = stall_i | (hazard & ~flush_i);
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            q    <= '0;
            hz_q <= 1'b0;
        end else if (flush_i) begin
            q    <= '0;
            hz_q <= 1'b0;
        end else if (!stall_i) begin
            q    <= (valid_i & ~hazard) ? dec : '0;
            hz_q <= hazard;
        end
    assign valid_o   = q.valid;
    assign form_o    = q.form;
    assign op_o      = q.op;
    assign riA_o     = RW'(q.ria);
    assign riB_o     = RW'(q.rib);
    assign reg_we_o  = q.reg_we;
    assign imm_o     = q.imm;
    assign mem_rd_o  = q.mem_rd;
    assign mem_wr_o  = q.mem_wr;
    assign illegal_o = q.illegal;
    assign PC_o      = q.pc;
endmodule

// File: tb/tb_cpu_decode.sv
// tb_cpu_decode: scoreboard bench for cpu_decode with directed cases and randomized instruction streams
module tb_cpu_decode;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [15:0] opcode_i;
    logic [31:0] operand_i;
    logic        valid_i;
    logic [31:0] PC_i;
    logic        stall_i;
    logic        flush_i;
    logic        stall_o;
    logic        valid_o;
    logic [1:0]  form_o;
    logic [7:0]  op_o;
    logic [3:0]  riA_o;
    logic [3:0]  riB_o;
    logic        reg_we_o;
    logic [31:0] imm_o;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic        illegal_o;
    logic [31:0] PC_o;
    int checks = 0;
    int errors = 0;
    always #5 clk_i = ~clk_i;
    cpu_decode dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .operand_i(operand_i), .valid_i(valid_i),
        .PC_i(PC_i), .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o), .valid_o(valid_o),
        .form_o(form_o), .op_o(op_o), .riA_o(riA_o), .riB_o(riB_o), .reg_we_o(reg_we_o), .imm_o(imm_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .illegal_o(illegal_o), .PC_o(PC_o)
    );
    typedef struct packed {
        logic [1:0]  form;
        logic [7:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        we;
        logic [31:0] imm;
        logic        rd;
        logic        wr;
        logic        ill;
        logic [31:0] pc;
    } exp_t;
    exp_t q[$];
    exp_t held;
    logic held_v = 1'b0;
    logic p_stall = 1'b0;
    logic p_flush = 1'b1;
    logic m_v;
    logic m_ld;
    logic [3:0] m_ra;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    function automatic bit is_opnd(int p);
        return p inside {'h01, 'h03, 'h08, 'h09, 'h0c, 'h0d, 'h1a, 'h1b, 'h1d, 'h1e, 'h20, 'h22, 'h23, ['h36:'h39]};
    endfunction
    function automatic bit is_ld(int p);
        return p inside {'h06, 'h08, 'h0c, 'h1c, 'h1d, 'h21, 'h22, 'h36, 'h38};
    endfunction
    function automatic bit is_st(int p);
        return p inside {'h09, 'h0b, 'h0d, 'h1e, 'h1f, 'h23, 'h24, 'h37, 'h39};
    endfunction
    function automatic bit is_def(int p);
        return p inside {['h01:'h15], ['h19:'h39]};
    endfunction
    function automatic bit is_wr(int p);
        return p inside {'h01, 'h02, 'h05, ['h10:'h15], 'h1b, 'h20, ['h26:'h2f], ['h31:'h34]};
    endfunction
    function automatic bit is_rr(int p);
        return p inside {'h02, 'h05, 'h0e, ['h10:'h15], ['h26:'h2f], ['h31:'h34]};
    endfunction
    function automatic exp_t ref_dec(int o, logic [31:0] w, logic [31:0] pc);
        exp_t e = '0;
        int p = o / 256;
        int off = o % 1024;
        e.pc = pc;
        e.rb = 4'(o % 16);
        if (o < 'h8000) begin
            e.form = 2'd0;
            e.op   = 8'(p);
            e.ra   = 4'(o / 16 % 16);
            e.imm  = is_opnd(p) ? w : 32'd0;
            e.rd   = is_ld(p);
            e.wr   = is_st(p);
            e.ill  = !is_def(p);
            e.we   = is_ld(p) || is_wr(p);
        end else if (o < 'hC000) begin
            e.form = 2'd2;
            e.op   = 8'(o / 4096 % 4);
            e.ra   = 4'(o / 256 % 16);
            e.imm  = 32'(o % 256);
            e.we   = (o / 4096 % 4) != 3;
        end else begin
            e.form = 2'd3;
            e.op   = 8'(o / 1024 % 16);
            e.imm  = 32'(off < 512 ? 2 * off : 2 * off - 2048);
        end
        return e;
    endfunction
    function automatic bit reads(int o, int r);
        int p = o / 256;
        if (o >= 'hC000) return 0;
        if (o >= 'h8000) return o / 256 % 16 == r;
        return (is_rr(p) && (o / 16 % 16 == r || o % 16 == r)) || (is_st(p) && o % 16 == r);
    endfunction
    task automatic cmp(input string t, input exp_t e);
        chk({t, ".form"}, 32'(form_o), 32'(e.form));
        chk({t, ".op"}, 32'(op_o), 32'(e.op));
        if (e.form != 2'd3) chk({t, ".riA"}, 32'(riA_o), 32'(e.ra));
        if (e.form == 2'd0) chk({t, ".riB"}, 32'(riB_o), 32'(e.rb));
        chk({t, ".imm"}, imm_o, e.imm);
        chk({t, ".ctl"}, {28'd0, reg_we_o, mem_rd_o, mem_wr_o, illegal_o}, {28'd0, e.we, e.rd, e.wr, e.ill});
        chk({t, ".pc"}, PC_o, e.pc);
    endtask
    always @(posedge clk_i) begin
        p_stall <= stall_i & rst_i;
        p_flush <= flush_i | !rst_i;
    end
    always @(negedge clk_i) if (rst_i) begin
        if (p_flush) begin
            chk("killed_valid", 32'(valid_o), 0);
            held_v = 1'b0;
        end else if (p_stall) begin
            chk("held_valid", 32'(valid_o), 32'(held_v));
            if (held_v) cmp("held", held);
        end else if (valid_o) begin
            if (q.size() == 0) chk("unexpected_valid", 32'(valid_o), 0);
            else begin
                held = q.pop_front();
                held_v = 1'b1;
                cmp("bundle", held);
            end
        end else held_v = 1'b0;
    end
    task automatic step(input logic v, input logic [15:0] o, input logic [31:0] w, input logic [31:0] pc,
                        input logic st, input logic fl, output logic acc);
        logic hz;
        exp_t e;
        valid_i = v; opcode_i = o; operand_i = w; PC_i = pc; stall_i = st; flush_i = fl;
        hz = v && m_v && m_ld && reads(int'(o), int'(m_ra));
        #2 chk("stall_o", 32'(stall_o), 32'(st || (hz && !fl)));
        acc = v && !st && !hz && !fl;
        @(posedge clk_i);
        if (fl) m_v = 1'b0;
        else if (!st) begin
            m_v = acc;
            if (acc) begin
                e = ref_dec(int'(o), w, pc);
                q.push_back(e);
                m_ld = e.rd;
                m_ra = e.ra;
            end
        end
        #1;
    endtask
    task automatic issue(input logic [15:0] o, input logic [31:0] w, input logic [31:0] pc);
        logic acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) step(1'b1, o, w, pc, 1'b0, 1'b0, acc);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL issue: opcode %h not accepted within 4 cycles", o);
        end
    endtask
    function automatic logic [15:0] rand_op();
        int k = $urandom_range(0, 7);
        int p = $urandom_range(0, 63);
        logic [3:0] a = 4'($urandom_range(0, 3));
        logic [3:0] b = 4'($urandom_range(0, 3));
        if (k < 2) while (!is_ld(p)) p = $urandom_range(0, 63);
        if (k == 7) p = $urandom_range(0, 127);
        if (k == 5) return {2'b10, 2'($urandom_range(0, 3)), a, 8'($urandom)};
        if (k == 6) return {2'b11, 14'($urandom)};
        return {8'(p), a, b};
    endfunction
    initial begin
        logic acc;
        logic [15:0] co;
        logic [31:0] cw;
        logic [31:0] cpc = 32'h4000;
        valid_i = 0; stall_i = 0; flush_i = 0; opcode_i = 0; operand_i = 0; PC_i = 0;
        m_v = 0; m_ld = 0; m_ra = 0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_pc", PC_o, 0);
        chk("rst_stall", 32'(stall_o), 0);
        rst_i = 1'b1;
        issue(16'h0123, 32'hDEADBEEF, 32'h1000);
        chk("ldi_valid", 32'(valid_o), 1);
        chk("ldi_form", 32'(form_o), 0);
        chk("ldi_op", 32'(op_o), 32'h01);
        chk("ldi_riA", 32'(riA_o), 2);
        chk("ldi_imm", imm_o, 32'hDEADBEEF);
        chk("ldi_we", 32'(reg_we_o), 1);
        chk("ldi_pc", PC_o, 32'h1000);
        issue(16'hC3FF, 32'h0, 32'h1006);
        chk("br_form", 32'(form_o), 3);
        chk("br_op", 32'(op_o), 0);
        chk("br_imm", imm_o, 32'hFFFFFFFE);
        chk("br_we", 32'(reg_we_o), 0);
        issue(16'h8A05, 32'h0, 32'h1008);
        chk("f2_form", 32'(form_o), 2);
        chk("f2_riA", 32'(riA_o), 32'hA);
        chk("f2_imm", imm_o, 5);
        issue(16'h0623, 32'h0, 32'h100A);
        step(1'b1, 16'h0532, 32'h0, 32'h100C, 1'b0, 1'b0, acc);
        chk("bubble_valid", 32'(valid_o), 0);
        issue(16'h0532, 32'h0, 32'h100C);
        chk("lu_valid", 32'(valid_o), 1);
        chk("lu_riB", 32'(riB_o), 2);
        issue(16'h0623, 32'h0, 32'h100E);
        issue(16'h0545, 32'h0, 32'h1010);
        chk("nolu_valid", 32'(valid_o), 1);
        chk("nolu_riA", 32'(riA_o), 4);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h0213, 32'h0, 32'h1012, 1'b1, 1'b0, acc);
            chk("stall_hold_pc", PC_o, 32'h1010);
        end
        step(1'b1, 16'h0213, 32'h0, 32'h1012, 1'b0, 1'b0, acc);
        chk("post_stall_pc", PC_o, 32'h1012);
        step(1'b1, 16'h0745, 32'h0, 32'h2000, 1'b1, 1'b1, acc);
        chk("flush_valid", 32'(valid_o), 0);
        repeat (2) step(1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        chk("flush_idle_valid", 32'(valid_o), 0);
        issue(16'h0623, 32'h0, 32'h2002);
        step(1'b1, 16'h0532, 32'h0, 32'h2004, 1'b0, 1'b1, acc);
        issue(16'h0000, 32'h0, 32'h2100);
        chk("bad_ill", 32'(illegal_o), 1);
        chk("bad_valid", 32'(valid_o), 1);
        issue(16'h0F00, 32'h0, 32'h2102);
        chk("nop_ill", 32'(illegal_o), 0);
        issue(16'h0623, 32'h0, 32'h3000);
        valid_i = 1; opcode_i = 16'h0532; stall_i = 0; flush_i = 0;
        #1 chk("il_stall", 32'(stall_o), 1);
        rst_i = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_o), 0);
        chk("arst_rd", 32'(mem_rd_o), 0);
        chk("arst_riA", 32'(riA_o), 0);
        chk("arst_pc", PC_o, 0);
        chk("arst_stall", 32'(stall_o), 0);
        q.delete();
        m_v = 0;
        valid_i = 0;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        co = rand_op();
        cw = $urandom;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 8, co, cw, cpc, $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0, acc);
            if (acc || flush_i) begin
                co = rand_op();
                cw = $urandom;
                cpc += 2;
            end
        end
        repeat (3) step(1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
